lut_table_loader: RTL and testbench
===================================

Name: lut_table_loader

Overview:
Write-side counterpart to the synchronous lookup-table ROM used by the temperature-conversion/display path. It accepts a stream of table entries over a valid/ready handshake and writes them sequentially into a synchronous single-port table RAM. It then reads the whole table back, using the same 1-cycle registered read latency as the ROM, and checks a running checksum. The block sits between a host/UART byte source and the table RAM that the display path later reads.

Parameters:
DATA_W, 7, width of one table entry (7-segment pattern / converted value)
DEPTH, 102, number of table entries, addresses 0..DEPTH-1
ADDR_W, 7, address width; must satisfy 2^ADDR_W >= DEPTH
SUM_W, 16, checksum width

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse that begins a load; ignored unless state is IDLE or DONE
in_data  input  DATA_W  entry to write
in_valid  input  1  in_data valid
in_ready  output  1  loader accepts in_data this cycle
mem_we  output  1  RAM write enable (registered)
mem_addr  output  ADDR_W  RAM address for write or read (registered)
mem_wdata  output  DATA_W  RAM write data (registered)
mem_rdata  input  DATA_W  RAM read data, valid 1 cycle after the address is presented
busy  output  1  high in LOAD, FLUSH, VERIFY
done  output  1  high in DONE until the next accepted start
error  output  1  checksum mismatch in the last run; valid while done=1
checksum  output  SUM_W  write-side checksum of the last load

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready, mem_we, busy, done, error = 0; mem_addr, mem_wdata, checksum, all counters and accumulators = 0.
- States: IDLE, LOAD, FLUSH, VERIFY, DONE.
- IDLE/DONE, start=1: go to LOAD. Clear wr_cnt, checksum, rd_acc, done, error.
- LOAD: in_ready = 1 (combinational from state). Accept occurs on in_valid & in_ready.
  - Next cycle after an accept: mem_we=1, mem_addr=wr_cnt, mem_wdata=in_data. Then checksum += zero-extended in_data (mod 2^SUM_W) and wr_cnt increments.
  - Cycle with no accept: mem_we=0 next cycle.
  - On the accept with wr_cnt==DEPTH-1, go to FLUSH. in_ready is low from the following cycle, so exactly DEPTH entries are accepted.
- FLUSH (1 cycle): the registered last write is on the RAM port (mem_we=1). No reads are issued this cycle. Then go to VERIFY with rd_cnt=0.
- VERIFY: mem_we=0. Present mem_addr=rd_cnt each cycle for rd_cnt=0..DEPTH-1.
  - A 1-bit valid pipeline marks that mem_rdata is valid 1 cycle after each address. rd_acc += mem_rdata on each valid.
  - After the DEPTH-th read datum is accumulated, go to DONE. Verify phase length is DEPTH+1 cycles.
- DONE: done=1, busy=0, error=(rd_acc != checksum). All outputs hold until start.
- start while busy: ignored, with no effect on counters.
- in_valid while not in LOAD: in_ready=0, data is not consumed, and the source must hold it.
- Address counters never wrap past DEPTH-1. Zero-value entries are written normally.
- Reset mid-operation: immediate return to IDLE. No further mem_we pulses. Partial table contents are undefined and are not retried.
- Checksum arithmetic: unsigned, modulo 2^SUM_W, with no saturation.
- Throughput: 1 entry/cycle when in_valid is held high. Total run = DEPTH + 1 + DEPTH + 1 cycles from the first accept to done.

Test Plan:
- Back-to-back load: in_valid held high, entries i%128 for i=0..101, ideal RAM model -> 102 writes at addr 0..101; checksum=0x141F; done=1, error=0; in_ready low from the cycle after the 102nd accept.
- Bubbled source: in_valid toggled 1/0 and randomly stalled for the same data -> identical RAM contents and checksum 0x141F; mem_we low in every cycle following a non-accept.
- Corrupting RAM: model flips bit 0 of addr 37 on readback -> done=1, error=1, checksum still 0x141F.
- start ignored: start pulsed in LOAD after 10 accepts and again in VERIFY -> wr_cnt unaffected; exactly 102 writes; run completes normally.
- Reset mid-load: rst_n=0 after 50 accepts -> busy, in_ready, mem_we = 0 in the same cycle; state IDLE. A new start then reloads from addr 0 and ends with done=1, error=0.
- Restart from DONE: second load of all 0x7F -> checksum=102*127=0x329A, error=0; done drops the cycle after start.

Source files
------------

// File: rtl/lut_table_loader.sv
// rtl/lut_table_loader.sv - streams DEPTH entries into a table RAM, then reads it back and checks the sum
module lut_table_loader #(
  parameter int DATA_W = 7,
  parameter int DEPTH  = 102,
  parameter int ADDR_W = 7,
  parameter int SUM_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [SUM_W-1:0]  checksum
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_FLUSH  = 3'd2;
  localparam logic [2:0] S_VERIFY = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   RD_END    = (ADDR_W + 1)'(DEPTH);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_W:0]   rd_cnt_q, rd_cnt_d;
  logic              rd_issue_q, rd_issue_d;
  logic              rd_vld_q, rd_vld_d;
  logic [SUM_W-1:0]  rd_acc_q, rd_acc_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [SUM_W-1:0]  checksum_q, checksum_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              accept;
  logic [SUM_W-1:0]  in_ext;
  logic [SUM_W-1:0]  rd_ext;

  assign in_ready = (state_q == S_LOAD);
  assign accept   = in_valid & in_ready;
  assign in_ext   = {{(SUM_W - DATA_W){1'b0}}, in_data};
  assign rd_ext   = {{(SUM_W - DATA_W){1'b0}}, mem_rdata};

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    rd_issue_d  = 1'b0;
    rd_vld_d    = rd_issue_q;
    rd_acc_d    = rd_acc_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    checksum_d  = checksum_q;
    done_d      = done_q;
    error_d     = error_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_LOAD;
          wr_cnt_d   = '0;
          checksum_d = '0;
          rd_acc_d   = '0;
          done_d     = 1'b0;
          error_d    = 1'b0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = wr_cnt_q;
          mem_wdata_d = in_data;
          checksum_d  = checksum_q + in_ext;
          if (wr_cnt_q == LAST_ADDR) begin
            state_d = S_FLUSH;
          end else begin
            wr_cnt_d = wr_cnt_q + ADDR_W'(1);
          end
        end
      end
      S_FLUSH: begin
        // Address 0 is registered here so it is on the port in the first VERIFY cycle.
        state_d    = S_VERIFY;
        mem_addr_d = '0;
        rd_cnt_d   = (ADDR_W + 1)'(1);
        rd_issue_d = 1'b1;
      end
      S_VERIFY: begin
        if (rd_cnt_q != RD_END) begin
          mem_addr_d = rd_cnt_q[ADDR_W-1:0];
          rd_cnt_d   = rd_cnt_q + (ADDR_W + 1)'(1);
          rd_issue_d = 1'b1;
        end
        if (rd_vld_q) begin
          rd_acc_d = rd_acc_q + rd_ext;
          // Valid with nothing behind it in flight is the last datum.
          if (!rd_issue_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            error_d = (rd_acc_d != checksum_q);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      rd_issue_q  <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_acc_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      checksum_q  <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_issue_q  <= rd_issue_d;
      rd_vld_q    <= rd_vld_d;
      rd_acc_q    <= rd_acc_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      checksum_q  <= checksum_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign checksum  = checksum_q;
  assign done      = done_q;
  assign error     = error_q;
  assign busy      = (state_q == S_LOAD) || (state_q == S_FLUSH) || (state_q == S_VERIFY);

endmodule

// File: tb/tb_lut_table_loader.sv
// tb/tb_lut_table_loader.sv - randomized load/verify runs against a queue-based table model
module tb_lut_table_loader;
  localparam int DATA_W = 7;
  localparam int DEPTH  = 102;
  localparam int ADDR_W = 7;
  localparam int SUM_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              busy, done, error;
  logic [SUM_W-1:0]  checksum;

  lut_table_loader #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .SUM_W(SUM_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .error(error), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // RAM model and bus monitor, sampled mid-cycle
  logic [DATA_W-1:0] ram [0:127];
  logic [DATA_W-1:0] rd_next = '0;
  bit   corrupt = 1'b0;
  int   cyc = 0;
  int   we_viol = 0;
  bit   prev_acc = 1'b0;
  int   wr_addr_q[$];
  int   wr_data_q[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      prev_acc <= 1'b0;
    end else begin
      if (mem_we !== prev_acc) we_viol <= we_viol + 1;
      prev_acc <= in_valid && in_ready;
      rd_next  <= ram[mem_addr] ^ ((corrupt && mem_addr == 7'd37) ? 7'd1 : 7'd0);
      if (mem_we === 1'b1) begin
        ram[mem_addr] <= mem_wdata;
        wr_addr_q.push_back(int'(mem_addr));
        wr_data_q.push_back(int'(mem_wdata));
      end
    end
  end

  always @(posedge clk) mem_rdata <= rd_next;

  logic [DATA_W-1:0] ent[$];

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  function automatic int model_sum(input logic [DATA_W-1:0] e[$]);
    int s = 0;
    foreach (e[i]) s += int'(e[i]);
    return s % 65536;
  endfunction

  function automatic int log_errors(input int base, input logic [DATA_W-1:0] e[$]);
    int bad = 0;
    for (int i = 0; i < e.size(); i++) begin
      if (base + i >= wr_addr_q.size()) bad++;
      else if (wr_addr_q[base+i] != i || wr_data_q[base+i] != int'(e[i])) bad++;
    end
    return bad;
  endfunction

  // mode 0: in_valid held high; mode 1: alternate idle cycles plus random stalls
  task automatic drive_load(input logic [DATA_W-1:0] e[$], input int mode, input int start_at,
                            input int stop_at, output int acc_cnt, output int first_cyc);
    int idx = 0;
    int guard = 0;
    bit t = 1'b0;
    bit v;
    first_cyc = -1;
    while (idx < e.size() && idx != stop_at && guard < 5000) begin
      v = (mode == 0) ? 1'b1 : (t ? 1'b0 : ($urandom_range(0, 3) != 0));
      t = ~t;
      in_valid = v;
      in_data  = v ? e[idx] : DATA_W'($urandom);
      if (idx == start_at) start = 1'b1;
      @(negedge clk);
      if (in_valid && in_ready) begin
        if (idx == 0) first_cyc = cyc;
        idx++;
      end
      @(posedge clk); #1;
      start = 1'b0;
      guard++;
    end
    acc_cnt = idx;
  endtask

  task automatic wait_done(input int limit, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dcyc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    in_valid = 1'b1;
    in_data  = 7'h55;
    #2;
    tests_run++;
    if ({in_ready, mem_we, busy, done, error, mem_addr, mem_wdata, checksum} !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: got rdy=%b we=%b busy=%b done=%b err=%b addr=%0h wd=%0h sum=%0h required all 0",
               in_ready, mem_we, busy, done, error, mem_addr, mem_wdata, checksum);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b0 || mem_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_no_accept: got in_ready=%b mem_we=%b required 0 0", in_ready, mem_we);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    int base, viol0, acc, fc, dc;
    ent = {};
    for (int i = 0; i < DEPTH; i++) ent.push_back(DATA_W'(i % 128));
    base = wr_addr_q.size(); viol0 = we_viol;
    pulse_start();
    drive_load(ent, 0, -1, -1, acc, fc);
    in_valid = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_ready_after_last: got in_ready=%b required 0", in_ready);
    end
    in_valid = 1'b0;
    wait_done(400, dc);
    tests_run++;
    if (dc < 0 || fc < 0 || dc - fc != 2 * DEPTH + 2) begin
      tests_failed++;
      $display("FAIL b2b_latency: got %0d cycles from first accept to done required %0d", dc - fc, 2 * DEPTH + 2);
    end
    tests_run++;
    if (int'(checksum) != model_sum(ent) || error !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_result: got sum=%0h err=%b busy=%b required sum=%0h err=0 busy=0",
               checksum, error, busy, model_sum(ent));
    end
    tests_run++;
    if (wr_addr_q.size() - base != DEPTH || log_errors(base, ent) != 0) begin
      tests_failed++;
      $display("FAIL b2b_writes: got %0d writes, %0d wrong required %0d writes, 0 wrong",
               wr_addr_q.size() - base, log_errors(base, ent), DEPTH);
    end
    tests_run++;
    if (we_viol - viol0 != 0) begin
      tests_failed++;
      $display("FAIL b2b_we_timing: got %0d mem_we cycles not matching prior accept required 0", we_viol - viol0);
    end
  endtask

  task automatic test_bubbled();
    int base, viol0, acc, fc, dc, bad;
    base = wr_addr_q.size(); viol0 = we_viol;
    pulse_start();
    drive_load(ent, 1, -1, -1, acc, fc);
    in_valid = 1'b0;
    wait_done(400, dc);
    tests_run++;
    if (dc < 0 || int'(checksum) != model_sum(ent) || error !== 1'b0) begin
      tests_failed++;
      $display("FAIL bubbled_result: got done_cyc=%0d sum=%0h err=%b required sum=%0h err=0",
               dc, checksum, error, model_sum(ent));
    end
    tests_run++;
    if (wr_addr_q.size() - base != DEPTH || log_errors(base, ent) != 0) begin
      tests_failed++;
      $display("FAIL bubbled_writes: got %0d writes required %0d in order", wr_addr_q.size() - base, DEPTH);
    end
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== ent[i]) bad++;
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL bubbled_ram: got %0d wrong entries required 0", bad);
    end
    tests_run++;
    if (we_viol - viol0 != 0) begin
      tests_failed++;
      $display("FAIL bubbled_we_timing: got %0d bad mem_we cycles required 0", we_viol - viol0);
    end
  endtask

  task automatic test_corrupt();
    int acc, fc, dc;
    corrupt = 1'b1;
    pulse_start();
    drive_load(ent, 0, -1, -1, acc, fc);
    in_valid = 1'b0;
    wait_done(400, dc);
    tests_run++;
    if (dc < 0 || error !== 1'b1 || int'(checksum) != model_sum(ent)) begin
      tests_failed++;
      $display("FAIL corrupt_detect: got done_cyc=%0d err=%b sum=%0h required err=1 sum=%0h",
               dc, error, checksum, model_sum(ent));
    end
    corrupt = 1'b0;
  endtask

  task automatic test_start_ignored();
    int base, acc, fc, dc;
    ent = {};
    for (int i = 0; i < DEPTH; i++) ent.push_back(DATA_W'($urandom));
    base = wr_addr_q.size();
    pulse_start();
    drive_load(ent, 0, 10, -1, acc, fc);
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(400, dc);
    tests_run++;
    if (acc != DEPTH || dc < 0 || int'(checksum) != model_sum(ent) || error !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_ignored_result: got acc=%0d done_cyc=%0d sum=%0h err=%b required acc=%0d sum=%0h err=0",
               acc, dc, checksum, error, DEPTH, model_sum(ent));
    end
    tests_run++;
    if (wr_addr_q.size() - base != DEPTH || log_errors(base, ent) != 0) begin
      tests_failed++;
      $display("FAIL start_ignored_writes: got %0d writes, %0d wrong required %0d, 0 wrong",
               wr_addr_q.size() - base, log_errors(base, ent), DEPTH);
    end
  endtask

  task automatic test_reset_mid_load();
    int base, acc, fc, dc, wsz;
    ent = {};
    for (int i = 0; i < DEPTH; i++) ent.push_back(DATA_W'(i % 128));
    pulse_start();
    drive_load(ent, 0, -1, 50, acc, fc);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || mem_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_load_outputs: got busy=%b in_ready=%b mem_we=%b required 0 0 0", busy, in_ready, mem_we);
    end
    in_valid = 1'b0;
    wsz = wr_addr_q.size();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    tests_run++;
    if (wr_addr_q.size() != wsz || done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_load_idle: got %0d extra writes done=%b busy=%b required 0 0 0",
               wr_addr_q.size() - wsz, done, busy);
    end
    base = wr_addr_q.size();
    pulse_start();
    drive_load(ent, 0, -1, -1, acc, fc);
    in_valid = 1'b0;
    wait_done(400, dc);
    tests_run++;
    if (dc < 0 || error !== 1'b0 || int'(checksum) != model_sum(ent) ||
        wr_addr_q.size() - base != DEPTH || log_errors(base, ent) != 0) begin
      tests_failed++;
      $display("FAIL reset_mid_load_reload: got done_cyc=%0d err=%b sum=%0h writes=%0d required err=0 sum=%0h writes=%0d",
               dc, error, checksum, wr_addr_q.size() - base, model_sum(ent), DEPTH);
    end
  endtask

  task automatic test_restart();
    int base, acc, fc, dc;
    ent = {};
    for (int i = 0; i < DEPTH; i++) ent.push_back(7'h7F);
    base = wr_addr_q.size();
    @(negedge clk);
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL restart_done_before: got done=%b required 1", done);
    end
    pulse_start();
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL restart_done_drop: got done=%b required 0", done);
    end
    drive_load(ent, 0, -1, -1, acc, fc);
    in_valid = 1'b0;
    wait_done(400, dc);
    tests_run++;
    if (dc < 0 || int'(checksum) != model_sum(ent) || error !== 1'b0 ||
        wr_addr_q.size() - base != DEPTH || log_errors(base, ent) != 0) begin
      tests_failed++;
      $display("FAIL restart_result: got done_cyc=%0d sum=%0h err=%b writes=%0d required sum=%0h err=0 writes=%0d",
               dc, checksum, error, wr_addr_q.size() - base, model_sum(ent), DEPTH);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_bubbled();
    test_corrupt();
    test_start_ignored();
    test_reset_mid_load();
    test_restart();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
